// File: rtl/rv_pkg.sv
// rv_pkg: shared register-index/data widths, write-back source enum and request struct
package rv_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN = 32;
  typedef enum logic {WB_ALU, WB_MEM} wb_src_e;
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters; ports clk/rst_n, issue (iss_valid/iss_rd/iss_ready), hazard query (rsN_idx/rsN_busy), retire (dec/dec_idx)
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rd,
  output logic                 iss_ready,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  input  logic                 dec,
  input  logic [REG_IDX_W-1:0] dec_idx
);
  logic [CNT_W-1:0] cnt [DEPTH];
  logic [DEPTH-1:0] inc_v, dec_v;
  logic dec_same;
  assign dec_same = dec && dec_idx == iss_rd;
  assign iss_ready = iss_rd == '0 || cnt[iss_rd] != '1 || dec_same;
  assign rs1_busy = rs1_idx != '0 && cnt[rs1_idx] != '0;
  assign rs2_busy = rs2_idx != '0 && cnt[rs2_idx] != '0;
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    inc_v[iss_rd] = iss_valid && iss_ready && iss_rd != '0;
    dec_v[dec_idx] = dec;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (!rst_n) cnt[i] <= '0;
      else if (inc_v[i] && !dec_v[i]) cnt[i] <= cnt[i] + CNT_W'(1);
      else if (dec_v[i] && !inc_v[i] && cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
    if (rst_n && dec) assert (cnt[dec_idx] != '0) else $error("scoreboard underflow");
  end
endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: round-robin ALU/load write-back arbiter driving registered regfile port (wr/c_idx/c) plus pending-write scoreboard
module regfile_wb
  import rv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rd,
  output logic                 iss_ready,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]     alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [WIDTH-1:0]     mem_data,
  output logic                 mem_ready,
  output logic                 wr,
  output logic [REG_IDX_W-1:0] c_idx,
  output logic [WIDTH-1:0]     c
);
  wb_src_e rr_last;
  logic alu_fire, mem_fire;
  assign alu_ready = !mem_valid || rr_last == WB_MEM;
  assign mem_ready = !alu_valid || rr_last == WB_ALU;
  assign alu_fire = alu_valid && alu_ready;
  assign mem_fire = mem_valid && mem_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr <= 1'b0;
      c_idx <= '0;
      c <= '0;
      rr_last <= WB_MEM;
    end else begin
      wr <= (alu_fire && alu_rd != '0) || (mem_fire && mem_rd != '0);
      c_idx <= alu_fire ? alu_rd : mem_fire ? mem_rd : c_idx;
      c <= alu_fire ? alu_data : mem_fire ? mem_data : c;
      rr_last <= (alu_valid && mem_valid) ? (alu_fire ? WB_ALU : WB_MEM) : rr_last;
    end
  end
  regfile_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_sb (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .dec(wr), .dec_idx(c_idx)
  );
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed-vector self-checking bench for regfile_wb
module tb_regfile_wb;
  logic clk = 1'b0, rst_n;
  logic iss_valid, iss_ready, rs1_busy, rs2_busy;
  logic [4:0] iss_rd, rs1_idx, rs2_idx, alu_rd, mem_rd, c_idx;
  logic alu_valid, alu_ready, mem_valid, mem_ready, wr;
  logic [31:0] alu_data, mem_data, c;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  regfile_wb dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr(wr), .c_idx(c_idx), .c(c)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [4:0] rd);
    @(negedge clk);
    iss_valid = 1'b1;
    iss_rd = rd;
    #1 check("iss_ready_issue", 32'(iss_ready), 32'd1);
  endtask
  initial begin
    logic [4:0] exp_idx [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
    rst_n = 1'b0;
    {iss_valid, alu_valid, mem_valid} = '0;
    {iss_rd, rs1_idx, rs2_idx, alu_rd, mem_rd} = '0;
    alu_data = '0;
    mem_data = '0;
    repeat (2) @(negedge clk);
    rs1_idx = 5'd5;
    #1 check("rst_wr", 32'(wr), 32'd0);
    check("rst_c_idx", 32'(c_idx), 32'd0);
    check("rst_c", c, 32'd0);
    check("rst_busy", 32'(rs1_busy), 32'd0);
    rst_n = 1'b1;
    issue(5'd5);
    @(negedge clk);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check("t1_busy", 32'(rs1_busy), 32'd1);
    check("t1_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    alu_valid = 1'b0;
    check("t1_wr", 32'(wr), 32'd1);
    check("t1_c_idx", 32'(c_idx), 32'd5);
    check("t1_c", c, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_wr_off", 32'(wr), 32'd0);
    check("t1_busy_off", 32'(rs1_busy), 32'd0);
    issue(5'd3); issue(5'd3); issue(5'd4); issue(5'd4);
    @(negedge clk);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    rs1_idx = 5'd3;
    rs2_idx = 5'd4;
    #1 check("t2_alu_first", 32'(alu_ready), 32'd1);
    check("t2_mem_first", 32'(mem_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_wr", 32'(wr), 32'd1);
      check("t2_c_idx", 32'(c_idx), 32'(exp_idx[i]));
      check("t2_c", c, exp_idx[i] == 5'd3 ? 32'h33 : 32'h44);
      if (i < 3) begin
        #1 check("t2_mem_grant", 32'(mem_ready), 32'(i % 2 == 0));
        check("t2_alu_grant", 32'(alu_ready), 32'(i % 2 == 1));
      end else begin
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #1 check("t2_rs1_drained", 32'(rs1_busy), 32'd0);
      end
    end
    @(negedge clk);
    check("t2_wr_off", 32'(wr), 32'd0);
    check("t2_rs2_drained", 32'(rs2_busy), 32'd0);
    rs1_idx = 5'd7;
    issue(5'd7);
    @(negedge clk);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7;
    #1 check("t3_busy_issued", 32'(rs1_busy), 32'd1);
    @(negedge clk);
    alu_valid = 1'b0;
    check("t3_wr", 32'(wr), 32'd1);
    check("t3_c_idx", 32'(c_idx), 32'd7);
    check("t3_busy_wr", 32'(rs1_busy), 32'd1);
    @(negedge clk);
    check("t3_busy_after", 32'(rs1_busy), 32'd0);
    rs1_idx = 5'd9;
    issue(5'd9); issue(5'd9); issue(5'd9);
    @(negedge clk);
    #1 check("t4_saturated", 32'(iss_ready), 32'd0);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9;
    #1 check("t4_alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1 check("t4_wr9", 32'(wr), 32'd1);
    check("t4_ready_dec", 32'(iss_ready), 32'd1);
    @(negedge clk);
    iss_valid = 1'b0;
    #1 check("t4_still_full", 32'(iss_ready), 32'd0);
    check("t4_busy", 32'(rs1_busy), 32'd1);
    @(negedge clk);
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h1234;
    #1 check("t5_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    mem_valid = 1'b0;
    rs1_idx = 5'd0;
    iss_rd = 5'd0;
    #1 check("t5_wr0", 32'(wr), 32'd0);
    check("t5_busy0", 32'(rs1_busy), 32'd0);
    check("t5_ready0", 32'(iss_ready), 32'd1);
    issue(5'd2);
    @(negedge clk);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    @(negedge clk);
    alu_valid = 1'b0;
    rst_n = 1'b0;
    check("t6_wr_pre", 32'(wr), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rs1_idx = 5'd2;
    rs2_idx = 5'd9;
    #1 check("t6_wr_dropped", 32'(wr), 32'd0);
    check("t6_busy2", 32'(rs1_busy), 32'd0);
    check("t6_busy9", 32'(rs2_busy), 32'd0);
    @(negedge clk);
    check("t6_wr_idle", 32'(wr), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
